// File: rtl/cordic_rot_iter_if.sv
// ----------------------------------------------------------------------------
// cordic_rot_iter_if
// Handshake bundle between an angle producer / result consumer and the
// iterative CORDIC rotation engine.
//   in_valid  : angle offered by the producer
//   in_ready  : engine idle, angle taken when in_valid & in_ready
//   in_angle  : signed angle, Q3.DATA_W radians
//   out_valid : engine holds a result
//   out_ready : consumer takes the result
//   out_cos   : signed cosine, Q2.(DATA_W-2)
//   out_sin   : signed sine,   Q2.(DATA_W-2)
// Modports: master = producer/consumer side, slave = engine side.
// ----------------------------------------------------------------------------
interface cordic_rot_iter_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W+2:0] in_angle;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_cos;
    logic signed [DATA_W-1:0] out_sin;

    modport master (
        output in_valid, in_angle, out_ready,
        input  in_ready, out_valid, out_cos, out_sin
    );

    modport slave (
        input  in_valid, in_angle, out_ready,
        output in_ready, out_valid, out_cos, out_sin
    );
endinterface

// File: rtl/cordic_rot_iter.sv
// ----------------------------------------------------------------------------
// cordic_rot_iter
// Iterative CORDIC rotation-mode engine: one micro-rotation per clock, result
// (cos, sin) of the accepted angle is presented ITER cycles after acceptance
// and held until the consumer takes it.
// Parameters:
//   DATA_W : output / arctangent table width (8..32)
//   ITER   : micro-rotations per result (1..DATA_W)
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : cordic_rot_iter_if.slave handshake bundle (angle in, cos/sin out)
// Optional feature:
//   CORDIC_QUAD_FOLD_EN : when defined, angles beyond +/-pi/2 are folded by
//   +/-pi on acceptance and both outputs are negated, extending the usable
//   input range to [-pi, pi] at no extra latency.
// ----------------------------------------------------------------------------
module cordic_rot_iter #(
    parameter int DATA_W = 16,
    parameter int ITER   = 16
) (
    input  logic               clk,
    input  logic               rst,
    cordic_rot_iter_if.slave   bus
);
    localparam int XW = DATA_W + 2;   // x/y: Q2.DATA_W
    localparam int ZW = DATA_W + 3;   // z:   Q3.DATA_W

    // CORDIC gain compensation, floor(0.6072529350 * 2^32) scaled to DATA_W.
    localparam logic [31:0]          K32    = 32'h9B74_EDA8;
    localparam logic signed [XW-1:0] K_INIT = XW'(K32 >> (32 - DATA_W));

`ifdef CORDIC_QUAD_FOLD_EN
    // floor(pi/2 * 2^32) and floor(pi * 2^32) scaled to DATA_W fraction bits.
    localparam logic [35:0]          HALF_PI36 = 36'h1_921F_B544;
    localparam logic [35:0]          PI36      = 36'h3_243F_6A88;
    localparam logic signed [ZW-1:0] HALF_PI   = ZW'(HALF_PI36 >> (32 - DATA_W));
    localparam logic signed [ZW-1:0] PI_FX     = ZW'(PI36 >> (32 - DATA_W));
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // floor(atan(2^-i) * 2^32); beyond i=10 the entry is 2^(32-i)-1.
    function automatic logic [31:0] atan32(input logic [5:0] idx);
        logic [31:0] v;
        case (idx)
            6'd0:    v = 32'hC90F_DAA2;
            6'd1:    v = 32'h76B1_9C15;
            6'd2:    v = 32'h3EB6_EBF2;
            6'd3:    v = 32'h1FD5_BA9A;
            6'd4:    v = 32'h0FFA_ADDB;
            6'd5:    v = 32'h07FF_556E;
            6'd6:    v = 32'h03FF_EAAB;
            6'd7:    v = 32'h01FF_FD55;
            6'd8:    v = 32'h00FF_FFAA;
            6'd9:    v = 32'h007F_FFF5;
            6'd10:   v = 32'h003F_FFFE;
            default: v = 32'hFFFF_FFFF >> idx;
        endcase
        return v;
    endfunction

    state_t                 state_r;
    state_t                 state_nx_s;
    logic                   accept_s;
    logic                   last_s;
    logic [5:0]             i_r;
    logic signed [XW-1:0]   x_r;
    logic signed [XW-1:0]   y_r;
    logic signed [ZW-1:0]   z_r;
    logic                   flag_r;
    logic signed [XW-1:0]   x_nx_s;
    logic signed [XW-1:0]   y_nx_s;
    logic signed [ZW-1:0]   z_nx_s;
    logic signed [ZW-1:0]   atan_z_s;
    logic [31:0]            atan_full_s;
    logic signed [ZW-1:0]   z_init_s;
    logic                   flag_init_s;
    logic signed [DATA_W-1:0] cos_nx_s;
    logic signed [DATA_W-1:0] sin_nx_s;
    logic                   out_valid_r;
    logic signed [DATA_W-1:0] out_cos_r;
    logic signed [DATA_W-1:0] out_sin_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode: accept only in IDLE, leave RUN after iteration ITER-1.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_r == 6'(ITER - 1)) begin
                    last_s     = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Starting angle, optionally folded into [-pi/2, pi/2].
    always_comb begin
        z_init_s    = bus.in_angle;
        flag_init_s = 1'b0;
`ifdef CORDIC_QUAD_FOLD_EN
        if (bus.in_angle > HALF_PI) begin
            z_init_s    = bus.in_angle - PI_FX;
            flag_init_s = 1'b1;
        end else if (bus.in_angle < -HALF_PI) begin
            z_init_s    = bus.in_angle + PI_FX;
            flag_init_s = 1'b1;
        end else begin
            z_init_s    = bus.in_angle;
            flag_init_s = 1'b0;
        end
`endif
    end

    // One micro-rotation; direction follows the sign of the residual angle.
    always_comb begin
        atan_full_s = atan32(i_r) >> (32 - DATA_W);
        atan_z_s    = ZW'(atan_full_s);
        if (!z_r[ZW-1]) begin
            x_nx_s = x_r - (y_r >>> i_r);
            y_nx_s = y_r + (x_r >>> i_r);
            z_nx_s = z_r - atan_z_s;
        end else begin
            x_nx_s = x_r + (y_r >>> i_r);
            y_nx_s = y_r - (x_r >>> i_r);
            z_nx_s = z_r + atan_z_s;
        end
        if (flag_r) begin
            cos_nx_s = DATA_W'(-(x_nx_s >>> 2));
            sin_nx_s = DATA_W'(-(y_nx_s >>> 2));
        end else begin
            cos_nx_s = DATA_W'(x_nx_s >>> 2);
            sin_nx_s = DATA_W'(y_nx_s >>> 2);
        end
    end

    // Datapath and result registers; the result is captured on the last
    // iteration so it is already stable on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_r         <= 6'd0;
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            flag_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_cos_r   <= '0;
            out_sin_r   <= '0;
        end else if (accept_s) begin
            i_r    <= 6'd0;
            x_r    <= K_INIT;
            y_r    <= '0;
            z_r    <= z_init_s;
            flag_r <= flag_init_s;
        end else if (state_r == ST_RUN) begin
            i_r <= i_r + 6'd1;
            x_r <= x_nx_s;
            y_r <= y_nx_s;
            z_r <= z_nx_s;
            if (last_s) begin
                out_valid_r <= 1'b1;
                out_cos_r   <= cos_nx_s;
                out_sin_r   <= sin_nx_s;
            end
        end else if ((state_r == ST_DONE) && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // in_ready is masked by rst so the engine never looks ready during reset.
    assign bus.in_ready  = (state_r == ST_IDLE) && !rst;
    assign bus.out_valid = out_valid_r;
    assign bus.out_cos   = out_cos_r;
    assign bus.out_sin   = out_sin_r;

endmodule

// File: tb/tb_cordic_rot_iter.sv
// ----------------------------------------------------------------------------
// tb_cordic_rot_iter
// Self-checking bench for cordic_rot_iter (DATA_W=16, ITER=16). Expected
// cos/sin come from a trigonometric reference (real $cos/$sin), not from a
// CORDIC model. Directed vectors live in a table; handshake stall and
// mid-run reset are hand-written sequences; random angles cover the range.
// ----------------------------------------------------------------------------
module tb_cordic_rot_iter;
    localparam int DW      = 16;
    localparam int IT      = 16;
    localparam int AW      = DW + 3;
    localparam int TOL     = 4;
    localparam int TOL_RND = 6;
`ifdef CORDIC_QUAD_FOLD_EN
    localparam int RANGE = 205887;
`else
    localparam int RANGE = 102943;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    cordic_rot_iter_if #(.DATA_W(DW)) bus ();

    cordic_rot_iter #(.DATA_W(DW), .ITER(IT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    angle;
        int    exp_cos;
        int    exp_sin;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp, input int tol);
        int diff;
        checks++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    function automatic int ref_cos(input int angle);
        return int'(16384.0 * $cos(real'(angle) / 65536.0));
    endfunction

    function automatic int ref_sin(input int angle);
        return int'(16384.0 * $sin(real'(angle) / 65536.0));
    endfunction

    // Offer an angle at a falling edge; returns just after the accepting edge.
    task automatic accept(input int angle);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_angle = AW'(angle);
        #1;
        check("accept_in_ready", int'(bus.in_ready), 1, 0);
        @(posedge clk);
    endtask

    // Count edges after acceptance until out_valid; in_valid/in_angle are
    // scrambled meanwhile, which must not disturb the running computation.
    task automatic wait_result(output int lat, output bit ok);
        int m;
        m = 0;
        @(negedge clk);
        while (!bus.out_valid && m < 40) begin
            bus.in_valid = ($urandom_range(1, 0) != 0);
            bus.in_angle = AW'($urandom);
            @(negedge clk);
            m++;
        end
        bus.in_valid = 1'b0;
        lat = m;
        ok  = bus.out_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: out_valid low after %0d cycles, expected high after %0d", m, IT);
        end
    endtask

    task automatic release_result(input string name);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, "_valid_drop"}, int'(bus.out_valid), 0, 0);
        check({name, "_ready_back"}, int'(bus.in_ready), 1, 0);
    endtask

    task automatic run_vector(input string name, input int angle, input int ec,
                              input int es, input int tol);
        int lat;
        bit ok;
        accept(angle);
        wait_result(lat, ok);
        if (ok) begin
            check({name, "_latency"}, lat, IT, 0);
            check({name, "_cos"}, int'(bus.out_cos), ec, tol);
            check({name, "_sin"}, int'(bus.out_sin), es, tol);
            release_result(name);
        end
    endtask

    initial begin
        int lat;
        bit ok;
        bit seen;

        bus.in_valid  = 1'b0;
        bus.in_angle  = '0;
        bus.out_ready = 1'b0;

        vecs.push_back('{"zero",   0,       16384,  0});
        vecs.push_back('{"pi4",    51471,   11585,  11585});
        vecs.push_back('{"mpi2",   -102943, 0,      -16384});
        vecs.push_back('{"mpi4",   -51471,  11585,  -11585});
        vecs.push_back('{"pi2",    102943,  0,      16384});
`ifdef CORDIC_QUAD_FOLD_EN
        vecs.push_back('{"pi",     205887,  -16384, 0});
        vecs.push_back('{"m3pi4",  -154415, -11585, -11585});
        vecs.push_back('{"3pi4",   154415,  -11585, 11585});
`endif

        // Reset held three cycles.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready_low", int'(bus.in_ready), 0, 0);
        check("reset_out_valid", int'(bus.out_valid), 0, 0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", int'(bus.in_ready), 1, 0);
        check("post_reset_out_valid", int'(bus.out_valid), 0, 0);
        check("post_reset_cos", int'(bus.out_cos), 0, 0);
        check("post_reset_sin", int'(bus.out_sin), 0, 0);

        // Directed table.
        for (int k = 0; k < vecs.size(); k++) begin
            run_vector(vecs[k].name, vecs[k].angle, vecs[k].exp_cos, vecs[k].exp_sin, TOL);
        end

        // Consumer stalls five cycles in DONE while new angles are offered.
        accept(51471);
        wait_result(lat, ok);
        if (ok) begin
            check("stall_latency", lat, IT, 0);
            for (int k = 0; k < 5; k++) begin
                bus.in_valid  = 1'b1;
                bus.in_angle  = AW'(k * 20000 - 40000);
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("stall_valid", int'(bus.out_valid), 1, 0);
                check("stall_cos", int'(bus.out_cos), 11585, TOL);
                check("stall_sin", int'(bus.out_sin), 11585, TOL);
                check("stall_in_ready", int'(bus.in_ready), 0, 0);
            end
            // Handshake with in_valid still high: no acceptance in DONE.
            bus.in_valid  = 1'b1;
            bus.in_angle  = AW'(0);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("stall_exit_valid", int'(bus.out_valid), 0, 0);
            check("stall_exit_in_ready", int'(bus.in_ready), 1, 0);
            @(posedge clk);
            wait_result(lat, ok);
            if (ok) begin
                check("after_stall_latency", lat, IT, 0);
                check("after_stall_cos", int'(bus.out_cos), 16384, TOL);
                check("after_stall_sin", int'(bus.out_sin), 0, TOL);
                release_result("after_stall");
            end
        end

        // Reset while iteration 8 is about to run.
        accept(51471);
        repeat (9) @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_valid", int'(bus.out_valid), 0, 0);
        check("midrst_cos", int'(bus.out_cos), 0, 0);
        check("midrst_sin", int'(bus.out_sin), 0, 0);
        check("midrst_in_ready_low", int'(bus.in_ready), 0, 0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", int'(bus.in_ready), 1, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst_no_valid_pulse", int'(seen), 0, 0);
        run_vector("post_rst_zero", 0, 16384, 0, TOL);

        // Random angles across the supported range.
        for (int r = 0; r < 30; r++) begin
            int a;
            a = int'($urandom_range(2 * RANGE, 0)) - RANGE;
            run_vector("rnd", a, ref_cos(a), ref_sin(a), TOL_RND);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
